ahb_slave_multiplexer: RTL and testbench
========================================

# ahb_slave_multiplexer

Slave-to-master return path of the AHB interconnect: it selects which slave's HRDATA, HREADYOUT and HRESP reach the master during the data phase. The slave select is registered from the address phase, tracking the one-cycle address/data pipeline and any wait states. An integrated default slave produces the two-cycle ERROR response for unmapped or ambiguous accesses. It sits between the address decoder and the master multiplexer and drives the system-wide HREADY.

## Interface
- DATA_WIDTH, 32: HRDATA width.
- NSLV, 16: number of slaves; slave i is selected by HSEL[i].
- HCLK  in  1  system clock; all state updates on the rising edge.
- HRESETn  in  1  synchronous, active-low reset.
- HSEL  in  NSLV  one-hot address-phase select from the decoder.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HRDATA_S  in  NSLV*DATA_WIDTH  concatenated slave read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- HREADYOUT_S  in  NSLV  per-slave ready.
- HRESP_S  in  NSLV*2  concatenated slave responses (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT).
- HRDATA  out  DATA_WIDTH  read data to the master.
- HREADY  out  1  transfer-complete signal to the master and to all slaves.
- HRESP  out  2  response to the master.
- ERRCNT  out  8  saturating count of default-slave ERROR responses.

## Operation
- **Data-phase select register `dsel`.** Values are slave index 0..NSLV-1, NONE, or DFLT. It loads only on an edge where HREADY=1, as follows:
  - exactly one HSEL bit set: load that index;
  - zero bits set and HTRANS is NONSEQ/SEQ: load DFLT;
  - zero bits set and HTRANS is IDLE/BUSY: load NONE;
  - more than one bit set: load DFLT, whatever HTRANS is.
- **dsel = i.** HRDATA = slave i's data, HREADY = HREADYOUT_S[i], HRESP = slave i's response. This path is combinational from `dsel` and the slave inputs.
- **dsel = NONE.** HRDATA=0, HREADY=1, HRESP=OKAY. This is a zero-wait OKAY.
- **dsel = DFLT.** HRDATA=0, and the default-slave FSM drives HREADY and HRESP.
- **Default-slave FSM.** States are IDLE, ERR1, ERR2.
  - IDLE→ERR1 on an edge where `dsel` loads DFLT.
  - In ERR1, HREADY=0 and HRESP=ERROR; the next edge always goes to ERR2.
  - In ERR2, HREADY=1 and HRESP=ERROR. The next edge goes to ERR1 if `dsel` reloads DFLT (back-to-back error), otherwise to IDLE.
- **ERRCNT.** Increments on each ERR1→ERR2 edge and saturates at 255.
- **Reset.** On an edge with HRESETn=0: `dsel`=NONE, FSM=IDLE, ERRCNT=0. The outputs are therefore HRDATA=0, HREADY=1, HRESP=OKAY. Reset takes priority over every other update, including in the middle of a wait state or in ERR1.

## Timing
- **Latency.** Selection takes effect one cycle after the address phase in which HREADY=1: the address phase is sampled at edge N, and the data-phase mux is valid after edge N.
- **Wait states.** While HREADY=0, `dsel` and the pending address-phase HSEL and HTRANS are ignored, so `dsel` holds across slave wait states.
- **Two-cycle ERROR rule.** The ERROR response is exactly two cycles: one with HREADY low, then one with HREADY high.
- **Slave responses.** A selected slave's own two-cycle ERROR/RETRY/SPLIT is passed through unmodified.
- **No combinational loop.** HREADY depends on HREADYOUT_S and registers only. There is no path from HSEL or HTRANS to HREADY.

## Structure
- **Shared package `ahb_pkg`.** It holds:
  - HTRANS encodings: TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ;
  - HRESP encodings: RESP_OKAY, RESP_ERROR, RESP_RETRY, RESP_SPLIT;
  - the default-slave state encoding.
- **Sub-module `ahb_default_slave`.** It contains the IDLE/ERR1/ERR2 FSM and ERRCNT. Its inputs are HCLK, HRESETn and a one-cycle `start` that is asserted when `dsel` loads DFLT. Its outputs are `ready`, `resp` and `errcnt`.
- **Top level.** It holds `dsel`, the one-hot check, and the output mux.

## Test plan
- **Reset.** Hold HRESETn=0 for 2 cycles with random slave inputs → HRDATA=0, HREADY=1, HRESP=OKAY, ERRCNT=0.
- **Zero-wait read.** HSEL=0x0004 with NONSEQ at edge N; slave 2 drives HRDATA=0xDEADBEEF, HREADYOUT=1 → master sees 0xDEADBEEF with HRESP=OKAY in cycle N+1.
- **Wait states.** Select slave 5, which holds HREADYOUT low for 3 cycles while HSEL changes to 0x0001 → `dsel` stays at 5 for all 3 wait cycles. Slave 0 is selected only after the cycle in which HREADY=1.
- **Unmapped NONSEQ.** HSEL=0 with NONSEQ → next cycle HREADY=0/ERROR, then HREADY=1/ERROR, then OKAY; ERRCNT=1. The same stimulus with IDLE instead → a zero-wait OKAY, ERRCNT unchanged.
- **Multiple HSEL bits.** HSEL=0x0003 with SEQ → two-cycle ERROR. Repeat 300 back-to-back → ERRCNT saturates at 255, with the FSM going ERR2→ERR1 directly.
- **Reset during ERR1.** Assert HRESETn=0 for one cycle while in ERR1 → next cycle HREADY=1, HRESP=OKAY, FSM=IDLE.

Source files
------------

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings for the slave-side return path:
//   - HTRANS transfer types
//   - HRESP response codes
//   - default-slave FSM state encoding
//   - data-phase select kind (which source owns the current data phase)
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_SLAVE = 2'd1,
        SEL_DFLT  = 2'd2
    } sel_kind_t;

    // NONSEQ and SEQ are the only transfer types that demand a response.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Answers unmapped / ambiguous accesses with the two-cycle AHB ERROR
// response and keeps a saturating count of the errors it has issued.
// Ports:
//   HCLK, HRESETn : clock, synchronous active-low reset
//   start         : one-cycle pulse when the data-phase select loads DFLT
//   ready         : HREADY contribution (low only in the first ERROR cycle)
//   resp          : HRESP contribution (ERROR while responding, else OKAY)
//   errcnt        : saturating count of ERROR responses issued
// ---------------------------------------------------------------------------
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       start,
    output logic       ready,
    output logic [1:0] resp,
    output logic [7:0] errcnt
);

    logic [1:0] state;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state  <= DS_IDLE;
            errcnt <= 8'd0;
        end else begin
            case (state)
                DS_IDLE: begin
                    if (start) state <= DS_ERR1;
                end
                DS_ERR1: begin
                    state <= DS_ERR2;
                    if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
                end
                DS_ERR2: begin
                    // A fresh DFLT load in the completing cycle chains the next error.
                    state <= start ? DS_ERR1 : DS_IDLE;
                end
                default: state <= DS_IDLE;
            endcase
        end
    end

    assign ready = (state != DS_ERR1);
    assign resp  = (state == DS_IDLE) ? RESP_OKAY : RESP_ERROR;

endmodule

// File: rtl/ahb_slave_multiplexer.sv
// ---------------------------------------------------------------------------
// ahb_slave_multiplexer
// Slave-to-master return path: registers the address-phase slave select into
// a data-phase select and routes that slave's HRDATA/HREADYOUT/HRESP to the
// master. Unmapped or multiply-selected accesses go to an integrated default
// slave that issues the two-cycle ERROR response.
// Ports:
//   HCLK, HRESETn         : clock, synchronous active-low reset
//   HSEL [NSLV]           : address-phase one-hot slave select
//   HTRANS [2]            : address-phase transfer type
//   HRDATA_S, HREADYOUT_S,
//   HRESP_S               : concatenated per-slave return signals
//   HRDATA, HREADY, HRESP : muxed data-phase response to the master
//   ERRCNT [8]            : saturating count of default-slave ERRORs
// ---------------------------------------------------------------------------
module ahb_slave_multiplexer
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NSLV       = 16
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [NSLV-1:0]            HSEL,
    input  logic [1:0]                 HTRANS,
    input  logic [NSLV*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NSLV-1:0]            HREADYOUT_S,
    input  logic [NSLV*2-1:0]          HRESP_S,
    output logic [DATA_WIDTH-1:0]      HRDATA,
    output logic                       HREADY,
    output logic [1:0]                 HRESP,
    output logic [7:0]                 ERRCNT
);

    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    sel_kind_t        dsel_kind;
    logic [IDX_W-1:0] dsel_idx;

    sel_kind_t        nxt_kind;
    logic [IDX_W-1:0] hsel_idx;
    logic             hsel_zero;
    logic             hsel_multi;
    logic             ds_start;
    logic             ds_ready;
    logic [1:0]       ds_resp;

    // Address-phase decode of HSEL: zero / exactly-one / several bits.
    always_comb begin
        hsel_idx = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (HSEL[i]) hsel_idx = IDX_W'(i);
        end
        hsel_zero  = (HSEL == '0);
        // Clearing the lowest set bit leaves something only if >1 bit was set.
        hsel_multi = ((HSEL & (HSEL - NSLV'(1))) != '0);

        if (hsel_multi) begin
            nxt_kind = SEL_DFLT;
        end else if (hsel_zero) begin
            nxt_kind = trans_active(HTRANS) ? SEL_DFLT : SEL_NONE;
        end else begin
            nxt_kind = SEL_SLAVE;
        end
    end

    // Data-phase select register; frozen across wait states.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel_kind <= SEL_NONE;
            dsel_idx  <= '0;
        end else if (HREADY) begin
            dsel_kind <= nxt_kind;
            dsel_idx  <= hsel_idx;
        end
    end

    assign ds_start = HREADY && (nxt_kind == SEL_DFLT);

    ahb_default_slave u_default_slave (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .start   (ds_start),
        .ready   (ds_ready),
        .resp    (ds_resp),
        .errcnt  (ERRCNT)
    );

    // Data-phase mux: depends only on registered state and slave outputs,
    // so HREADY never loops back through HSEL/HTRANS.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        case (dsel_kind)
            SEL_SLAVE: begin
                HRDATA = HRDATA_S[dsel_idx*DATA_WIDTH +: DATA_WIDTH];
                HREADY = HREADYOUT_S[dsel_idx];
                HRESP  = HRESP_S[dsel_idx*2 +: 2];
            end
            SEL_DFLT: begin
                HREADY = ds_ready;
                HRESP  = ds_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_multiplexer.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_multiplexer
// Directed and randomized stimulus against a transaction-level model of the
// return path: the model tracks who owns the data phase (slave index, nobody,
// or the default slave with its error-cycle number) and the error count.
// ---------------------------------------------------------------------------
module tb_ahb_slave_multiplexer;

    localparam int DW = 32;
    localparam int NS = 16;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [NS-1:0]     HSEL;
    logic [1:0]        HTRANS;
    logic [NS*DW-1:0]  HRDATA_S;
    logic [NS-1:0]     HREADYOUT_S;
    logic [NS*2-1:0]   HRESP_S;
    logic [DW-1:0]     HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [7:0]        ERRCNT;

    int total = 0;
    int bad   = 0;

    // Model: owner >= 0 slave index, -1 nobody (zero-wait OKAY), -2 default slave.
    int m_owner;
    int m_errcyc;   // 1 = first ERROR cycle, 2 = second ERROR cycle
    int m_cnt;

    always #5 HCLK = ~HCLK;

    ahb_slave_multiplexer #(.DATA_WIDTH(DW), .NSLV(NS)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .ERRCNT      (ERRCNT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_out(output logic [31:0] ed, output logic er, output logic [1:0] ep);
        if (m_owner >= 0) begin
            ed = HRDATA_S[m_owner*DW +: DW];
            er = HREADYOUT_S[m_owner];
            ep = HRESP_S[m_owner*2 +: 2];
        end else if (m_owner == -1) begin
            ed = 32'h0; er = 1'b1; ep = 2'b00;
        end else begin
            ed = 32'h0; er = (m_errcyc == 2); ep = 2'b01;
        end
    endtask

    task automatic model_update(input logic cur_ready);
        int n;
        n = $countones(HSEL);
        if (!HRESETn) begin
            m_owner = -1; m_errcyc = 0; m_cnt = 0;
        end else if (m_owner == -2 && m_errcyc == 1) begin
            m_errcyc = 2;
            if (m_cnt < 255) m_cnt++;
        end else if (cur_ready) begin
            if (n == 1) begin
                for (int i = 0; i < NS; i++) if (HSEL[i]) m_owner = i;
                m_errcyc = 0;
            end else if (n == 0 && HTRANS < 2) begin
                m_owner = -1; m_errcyc = 0;
            end else begin
                m_owner = -2; m_errcyc = 1;
            end
        end
    endtask

    // Inputs are already set; check the data phase, then take one edge.
    task automatic cycle();
        logic [31:0] ed;
        logic        er;
        logic [1:0]  ep;
        #1;
        exp_out(ed, er, ep);
        check("hrdata", HRDATA, ed);
        check("hready", {31'd0, HREADY}, {31'd0, er});
        check("hresp",  {30'd0, HRESP}, {30'd0, ep});
        check("errcnt", {24'd0, ERRCNT}, m_cnt);
        @(posedge HCLK);
        model_update(er);
        #1;
    endtask

    task automatic rand_slaves();
        for (int i = 0; i < NS; i++) begin
            HRDATA_S[i*DW +: DW] = $urandom;
            HRESP_S[i*2 +: 2]    = 2'($urandom_range(0, 3));
            HREADYOUT_S[i]       = ($urandom_range(0, 4) != 0);
        end
    endtask

    initial begin
        m_owner = -1; m_errcyc = 0; m_cnt = 0;
        HRESETn = 1'b0;
        HSEL    = NS'($urandom);
        HTRANS  = 2'($urandom_range(0, 3));
        rand_slaves();

        // Reset held for two edges with random slave inputs.
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_hready", {31'd0, HREADY}, 32'd1);
        check("rst_hresp",  {30'd0, HRESP}, 32'd0);
        check("rst_errcnt", {24'd0, ERRCNT}, 32'd0);
        HRESETn = 1'b1;
        HSEL = '0; HTRANS = 2'b00;
        cycle();

        // Zero-wait read from slave 2.
        HSEL = 16'h0004; HTRANS = 2'b10;
        cycle();
        HSEL = '0; HTRANS = 2'b00;
        HREADYOUT_S = '1;
        HRDATA_S[2*DW +: DW] = 32'hDEADBEEF;
        HRESP_S[2*2 +: 2] = 2'b00;
        #1;
        check("read_deadbeef", HRDATA, 32'hDEADBEEF);
        check("read_okay", {30'd0, HRESP}, 32'd0);
        cycle();

        // Slave 5 inserts three wait states while HSEL moves to slave 0.
        HSEL = 16'h0020; HTRANS = 2'b10;
        cycle();
        HSEL = 16'h0001; HTRANS = 2'b10;
        for (int w = 0; w < 3; w++) begin
            rand_slaves();
            HREADYOUT_S[5] = 1'b0;
            HRDATA_S[5*DW +: DW] = 32'h5500_0000 + w;
            #1;
            check("wait_hold_data", HRDATA, 32'h5500_0000 + w);
            check("wait_hready_low", {31'd0, HREADY}, 32'd0);
            cycle();
        end
        rand_slaves();
        HREADYOUT_S[5] = 1'b1;
        cycle();
        HSEL = '0; HTRANS = 2'b00;
        rand_slaves();
        HRDATA_S[0 +: DW] = 32'h0000_A0A0;
        #1;
        check("slave0_after_wait", HRDATA, 32'h0000_A0A0);
        cycle();

        // Unmapped NONSEQ: ERROR low, ERROR high, then OKAY.
        HREADYOUT_S = '1;
        HSEL = '0; HTRANS = 2'b10;
        cycle();
        HTRANS = 2'b00;
        #1;
        check("unmapped_err1_ready", {31'd0, HREADY}, 32'd0);
        check("unmapped_err1_resp", {30'd0, HRESP}, 32'd1);
        cycle();
        check("unmapped_err2_ready", {31'd0, HREADY}, 32'd1);
        check("unmapped_err2_resp", {30'd0, HRESP}, 32'd1);
        cycle();
        check("unmapped_okay", {30'd0, HRESP}, 32'd0);
        check("unmapped_errcnt", {24'd0, ERRCNT}, 32'd1);
        // Same with IDLE: zero-wait OKAY.
        cycle();
        cycle();
        check("idle_unmapped_ready", {31'd0, HREADY}, 32'd1);
        check("idle_unmapped_errcnt", {24'd0, ERRCNT}, 32'd1);

        // Multiple HSEL bits, back-to-back until the counter saturates.
        HSEL = 16'h0003; HTRANS = 2'b11;
        for (int k = 0; k < 600; k++) cycle();
        HSEL = '0; HTRANS = 2'b00;
        cycle();
        cycle();
        check("errcnt_saturated", {24'd0, ERRCNT}, 32'd255);

        // Reset while in ERR1.
        HSEL = '0; HTRANS = 2'b10;
        cycle();
        HRESETn = 1'b0;
        HTRANS = 2'b10;
        #1;
        check("rst_err1_in_err1", {31'd0, HREADY}, 32'd0);
        cycle();
        HRESETn = 1'b1;
        HTRANS = 2'b00;
        #1;
        check("rst_err1_ready", {31'd0, HREADY}, 32'd1);
        check("rst_err1_resp", {30'd0, HRESP}, 32'd0);
        check("rst_err1_errcnt", {24'd0, ERRCNT}, 32'd0);
        cycle();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      HSEL = '0;
            else if (r == 1) HSEL = NS'((1 << $urandom_range(0, 7)) | (1 << $urandom_range(8, 15)));
            else             HSEL = NS'(1 << $urandom_range(0, NS-1));
            HTRANS  = 2'($urandom_range(0, 3));
            HRESETn = ($urandom_range(0, 39) != 0);
            rand_slaves();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
